uart_cmd_ctrl: RTL
==================

# uart_cmd_ctrl

Byte-level command controller that sits directly behind the UART receiver (`o_Rx_DV` / `o_Rx_Byte`). It parses fixed-length checksummed frames from the host and writes the SDR runtime configuration registers: NCO frequency word, demod mode and gain. It holds the registered values that drive the DSP datapath. It issues a one-cycle update strobe on every committed write, and it counts framing errors.

## Interface
Parameters:
- `TIMEOUT_CLKS`, default 23100. Allowed inter-byte gap in clocks before an open frame is abandoned; about 2 byte times at 1155 clocks/bit. Range 2..65535.
- `FREQ_RESET`, default 32'h0000_0000. Reset value of `o_freq_word`.
- `MODE_RESET`, default 8'h00. Reset value of `o_mode`.
- `GAIN_RESET`, default 8'h10. Reset value of `o_gain`.

Ports:
- `osc_clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_rx_dv`  in  1  byte-valid strobe from the UART receiver, one cycle wide.
- `i_rx_byte`  in  8  received byte; valid only while `i_rx_dv`=1.
- `o_freq_word`  out  32  NCO phase-increment word.
- `o_mode`  out  8  demodulator mode register.
- `o_gain`  out  8  audio/IF gain register.
- `o_cfg_upd`  out  1  one-cycle pulse when any register is written.
- `o_err`  out  1  one-cycle pulse on a frame error.
- `o_err_cnt`  out  8  saturating frame-error count.

## Operation
- Frame format: 7 bytes, `0xA5`, ADDR, D3, D2, D1, D0, CHK. D3 is the MSB.
- Checksum rule: CHK = ADDR ^ D3 ^ D2 ^ D1 ^ D0. The sync byte is excluded.
- Address map:
  - 0x00 loads `o_freq_word` = {D3,D2,D1,D0}.
  - 0x01 loads `o_mode` = D0.
  - 0x02 loads `o_gain` = D0.
  - Any other address is an error and causes no write.
- State machine, with byte events qualified by `i_rx_dv`:
  - IDLE: a byte equal to 0xA5 moves to ADDR. Any other byte is discarded silently and is not an error.
  - ADDR: latch ADDR, seed the running XOR with it, clear the data index, move to DATA.
  - DATA: shift the byte into a 32-bit shift register and XOR it into the running checksum. After the 4th data byte (index 3), move to CHK.
  - CHK: if the byte matches the running XOR and ADDR ≤ 0x02, move to COMMIT. Otherwise pulse the error and move to IDLE.
  - COMMIT: write the addressed register, pulse `o_cfg_upd`, return to IDLE. This state lasts exactly 1 cycle.
- 0xA5 has no special meaning inside a frame. Fields are positional only.
- Timeout:
  - A 16-bit gap counter clears on every `i_rx_dv` and increments otherwise, saturating.
  - In ADDR, DATA or CHK, when the counter reaches `TIMEOUT_CLKS-1`, go to IDLE and pulse the error.
  - The counter is ignored in IDLE.
- Error handling: each error pulse increments `o_err_cnt`, which saturates at 0xFF. It clears only on reset.

## Timing
- Reset (async assert, sync use after deassert):
  - State = IDLE.
  - `o_freq_word`=FREQ_RESET, `o_mode`=MODE_RESET, `o_gain`=GAIN_RESET.
  - `o_cfg_upd`=0, `o_err`=0, `o_err_cnt`=0.
  - Gap counter = 0, shift register = 0, running XOR = 0.
- All outputs are registered. There are no combinational paths from input to output.
- Commit latency: CHK byte's `i_rx_dv` sampled at edge k → state=COMMIT after edge k. At edge k+1 the register update and `o_cfg_upd`=1 take effect together; `o_cfg_upd` returns to 0 at edge k+2.
- Error latency: `o_err` is high for exactly the cycle after the edge that detects the error. `o_err_cnt` updates on that same edge.
- Unwritten registers hold their values across all frames and errors.
- Simultaneous events:
  - If `i_rx_dv` and timeout expiry coincide in the same cycle, the byte wins and no timeout occurs.
  - An `i_rx_dv` during COMMIT is processed with IDLE rules; a 0xA5 there moves to ADDR.
- Reset mid-frame: the partial frame is discarded with no write and no error count.
- `i_rx_byte` is sampled only when `i_rx_dv`=1. Its value at any other time has no effect.

## Test plan
- Frequency write: send A5 00 12 34 56 78 08.
  - Required: `o_freq_word`=0x12345678 and a single `o_cfg_upd` pulse 2 edges after the CHK strobe.
  - `o_mode` and `o_gain` unchanged; `o_err_cnt`=0.
- Mode and gain writes: send A5 01 00 00 00 03 02, then A5 02 00 00 00 40 42.
  - Required: `o_mode`=0x03, `o_gain`=0x40, two `o_cfg_upd` pulses, freq unchanged.
- Bad checksum: send A5 00 12 34 56 78 09.
  - Required: no write, one `o_err` pulse, `o_err_cnt`=1.
  - A following valid frame commits normally.
- Bad address: send A5 07 00 00 00 01 06.
  - Required: no register change, `o_err_cnt` increments.
- Timeout: send A5 00 12, then idle for `TIMEOUT_CLKS` clocks.
  - Required: one `o_err` pulse, state IDLE.
  - Trailing bytes 34 56 78 08 cause no write and no further error.
  - Repeat with the gap equal to `TIMEOUT_CLKS-2`: the frame commits.
- Garbage, saturation and reset:
  - Bytes 00 FF 5A in IDLE → no error.
  - 260 bad-checksum frames → `o_err_cnt`=0xFF.
  - `rst` asserted mid-frame → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Command frame parser behind the UART receiver: decodes checksummed 7-byte
// frames into the NCO frequency, demod mode and gain registers.
module uart_cmd_ctrl #(
  parameter int          TIMEOUT_CLKS = 23100,
  parameter logic [31:0] FREQ_RESET   = 32'h0000_0000,
  parameter logic [7:0]  MODE_RESET   = 8'h00,
  parameter logic [7:0]  GAIN_RESET   = 8'h10
) (
  input  logic        osc_clk,
  input  logic        rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic [31:0] o_freq_word,
  output logic [7:0]  o_mode,
  output logic [7:0]  o_gain,
  output logic        o_cfg_upd,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [15:0] GAP_LIMIT = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_COMMIT
  } state_t;

  state_t      state;
  logic [15:0] gap_cnt;
  logic [7:0]  addr_q;
  logic [7:0]  run_xor;
  logic [31:0] shift_q;
  logic [1:0]  data_idx;

  logic in_frame;
  logic timeout;
  logic chk_ok;
  logic err_evt;

  // A byte arriving on the expiry cycle wins, so timeout requires a quiet cycle.
  assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign timeout  = !i_rx_dv && (gap_cnt == GAP_LIMIT);
  assign chk_ok   = (i_rx_byte == run_xor) && (addr_q <= 8'h02);
  assign err_evt  = (in_frame && timeout) ||
                    ((state == S_CHK) && i_rx_dv && !chk_ok);

  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      addr_q      <= '0;
      run_xor     <= '0;
      shift_q     <= '0;
      data_idx    <= '0;
      o_freq_word <= FREQ_RESET;
      o_mode      <= MODE_RESET;
      o_gain      <= GAIN_RESET;
      o_cfg_upd   <= 1'b0;
      o_err       <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      o_cfg_upd <= 1'b0;
      o_err     <= err_evt;
      if (err_evt && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;

      if (i_rx_dv)                  gap_cnt <= '0;
      else if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) state <= S_ADDR;
        end
        S_ADDR: begin
          if (i_rx_dv) begin
            addr_q   <= i_rx_byte;
            run_xor  <= i_rx_byte;
            data_idx <= '0;
            state    <= S_DATA;
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (i_rx_dv) begin
            shift_q  <= {shift_q[23:0], i_rx_byte};
            run_xor  <= run_xor ^ i_rx_byte;
            data_idx <= data_idx + 2'd1;
            if (data_idx == 2'd3) state <= S_CHK;
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_CHK: begin
          if (i_rx_dv)      state <= chk_ok ? S_COMMIT : S_IDLE;
          else if (timeout) state <= S_IDLE;
        end
        S_COMMIT: begin
          case (addr_q)
            8'h00:   o_freq_word <= shift_q;
            8'h01:   o_mode      <= shift_q[7:0];
            8'h02:   o_gain      <= shift_q[7:0];
            default: ;
          endcase
          o_cfg_upd <= 1'b1;
          // A byte landing during commit is handled as if already idle.
          if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) state <= S_ADDR;
          else                                     state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
